vector_lane_engine: RTL and testbench
=====================================

// Module: vector_lane_engine
// PURPOSE
// Parametrised multi-lane vector ALU. It processes LANES elements per cycle
// over a NUM_REGS x VEC_ELEMS register file.
// Instructions arrive over a valid/ready issue port. Vectors stream in and out
// over valid/ready data ports LANES elements wide.
// Adds variable vector length with lane masking, saturating arithmetic, MIN/MAX
// and an accumulator clear. It sits between the instruction sequencer and the
// data-mover streams.
// PARAMETERS
// ELEM_W     16  signed element width (bits)
// LANES      4   elements processed per beat; VEC_ELEMS % LANES == 0
// VEC_ELEMS  16  elements per vector register
// NUM_REGS   16  vector registers, <=16 (4-bit index)
// ACC_W      40  per-element MAC accumulator width, >= 2*ELEM_W
// PORTS
// clock       in   1               single clock, rising edge
// reset       in   1               synchronous, active-high
// instr_valid in   1               instruction offered
// instr_ready out  1               engine accepts instruction
// instr       in   32              [31:28]op [27:24]src1 [23:20]src2 [19:16]dest [15:8]vl [7:0]flags
// in_valid    in   1               LOAD beat offered
// in_ready    out  1               LOAD beat accepted
// in_data     in   LANES*ELEM_W    lane k at bits [k*ELEM_W +: ELEM_W]
// out_valid   out  1               STORE beat offered
// out_ready   in   1               STORE beat accepted
// out_data    out  LANES*ELEM_W    same lane packing as in_data
// busy        out  1               state != IDLE
// done        out  1               1-cycle pulse on instruction completion
// err         out  1               1-cycle pulse with done on illegal opcode
// BEHAVIOUR
// Reset:
// - state=IDLE; all registers, accumulators and outputs = 0.
// - instr_ready=1 in the first cycle after reset deasserts.
// - Reset mid-instruction aborts it. No partial write survives, because the register file is cleared.
// Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 MUL, 6 MAC, 7 MIN, 8 MAX, 9 MOVE.
// - Opcodes 10-15 are illegal.
// Flags: flags[0] = saturate; flags[1] = clear accumulators before MAC. Other flag bits are ignored.
// Vector length:
// - vl=0 or vl>VEC_ELEMS means VEC_ELEMS.
// - beats B = ceil(vl/LANES).
// - Elements with index >= vl are never written. On STORE, masked lanes output 0.
// FSM: IDLE -> EXEC | LOAD | STORE -> DONE -> IDLE.
// - instr_ready = (state==IDLE). An instruction is accepted on instr_valid && instr_ready in cycle T.
// - EXEC (ops 3-9): one beat per cycle, in cycles T+1..T+B. done pulses in T+B+1; IDLE in T+B+2.
// - NOP and illegal opcodes go straight to DONE at T+1. err=1 only for illegal opcodes; no state changes.
// - LOAD: in_ready=1 only in LOAD. A beat advances on in_valid && in_ready. Stalls are unbounded.
// - STORE: out_valid=1 in STORE. out_data is held stable until out_valid && out_ready. The beat then advances.
// - The next STORE beat is presented in the cycle following the handshake.
// - The last handshake moves the FSM to DONE.
// Arithmetic (signed two's complement, per element):
// - ADD, SUB and MUL compute at full precision.
// - When saturating, results clamp to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1]. Otherwise they take the low ELEM_W bits (wrap).
// - MAC: acc[e] = (flags[1] ? 0 : acc[e]) + src1*src2. acc wraps at ACC_W.
//   dest[e] = the new acc, saturated or truncated per flags[0].
// - MIN/MAX: signed compare. MOVE: dest=src1. src2 is ignored for MOVE, LOAD and STORE.
// - Aliasing of dest with src1 or src2 is legal; each beat reads the values from before that beat.
// - acc persists across instructions. Only reset or a MAC with flags[1] clears it.
// TESTING (ELEM_W=16, LANES=4, VEC_ELEMS=16)
// 1. LOAD r1 vl=0 with data 1..16 in 4 beats, in_valid gapped.
//    -> 4 accepts, then a done pulse.
//    Then STORE r1 with out_ready toggled every cycle -> 1..16 in order, out_data stable while stalled.
// 2. r1=0x7FF0 and r2=0x0020 in all elements; ADD r3=r1+r2.
//    -> flags=1: 0x7FFF in all elements. flags=0: 0x8010.
// 3. r1=3 and r2=4; MAC flags=2 then MAC flags=0 to r5.
//    -> r5 = 12 then 24. r1=-200 and r2=300 with sat gives -32768.
// 4. ADD with vl=5 accepted at T.
//    -> 2 beats; done at T+3; elements 5..15 of dest unchanged; STORE vl=0 shows this.
// 5. op=0xF issued; second instr_valid held.
//    -> done=err=1 at T+1; registers unchanged; second instruction accepted at T+2.
// 6. reset asserted after 2 LOAD beats.
//    -> next cycle: busy=0, instr_ready=1. A subsequent STORE returns all zeros.

Source files
------------

// File: rtl/vector_lane_engine.sv
`default_nettype none
// ============================================================================
// Module      : vector_lane_engine
// Description : Multi-lane signed vector ALU over a NUM_REGS x VEC_ELEMS
//               register file, with valid/ready instruction issue, LOAD/STORE
//               streaming, vector-length lane masking, saturation and a
//               per-element MAC accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_lane_engine #(
    parameter int ELEM_W    = 16,
    parameter int LANES     = 4,
    parameter int VEC_ELEMS = 16,
    parameter int NUM_REGS  = 16,
    parameter int ACC_W     = 40
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [31:0]               instr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ELEM_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*ELEM_W-1:0]   out_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int BEATS_MAX = VEC_ELEMS / LANES;
    localparam int BEAT_W    = $clog2(BEATS_MAX + 1);
    localparam int VL_W      = $clog2(VEC_ELEMS + 1);
    localparam int EIDX_W    = (VEC_ELEMS > 1) ? $clog2(VEC_ELEMS) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_EXEC  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_STORE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_MAC   = 4'd6;
    localparam logic [3:0] OP_MIN   = 4'd7;
    localparam logic [3:0] OP_MAX   = 4'd8;
    localparam logic [3:0] OP_MOVE  = 4'd9;
    localparam logic [3:0] OP_FIRST_ILLEGAL = 4'd10;

    // Saturation bounds expressed at accumulator width so every result
    // (sum, difference, product, accumulator) can be clamped the same way.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-ELEM_W+1){1'b0}}, {(ELEM_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-ELEM_W+1){1'b1}}, {(ELEM_W-1){1'b0}}};

    logic [2:0]               state_q, state_d;
    logic [3:0]               op_q, op_d;
    logic [3:0]               src1_q, src1_d;
    logic [3:0]               src2_q, src2_d;
    logic [3:0]               dest_q, dest_d;
    logic                     sat_q, sat_d;
    logic                     clr_q, clr_d;
    logic [VL_W-1:0]          vl_q, vl_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic signed [ELEM_W-1:0] rf_q  [NUM_REGS][VEC_ELEMS];
    logic signed [ELEM_W-1:0] rf_d  [NUM_REGS][VEC_ELEMS];
    logic signed [ACC_W-1:0]  acc_q [VEC_ELEMS];
    logic signed [ACC_W-1:0]  acc_d [VEC_ELEMS];

    logic [VL_W-1:0]          vl_accept;
    logic                     beat_last;
    logic                     unused_flag_bits;

    // Flag bits above bit 1 carry no meaning for this engine.
    assign unused_flag_bits = ^instr[7:2];

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [ELEM_W-1:0] v);
        return {{(ACC_W-ELEM_W){v[ELEM_W-1]}}, v};
    endfunction

    function automatic logic signed [ELEM_W-1:0] clamp(input logic signed [ACC_W-1:0] v,
                                                        input logic sat);
        if (sat && (v > SAT_MAX)) return SAT_MAX[ELEM_W-1:0];
        if (sat && (v < SAT_MIN)) return SAT_MIN[ELEM_W-1:0];
        return v[ELEM_W-1:0];
    endfunction

    // Effective vector length: zero or oversize requests mean a full vector.
    always_comb begin
        vl_accept = VL_W'(instr[15:8]);
        if ((instr[15:8] == 8'd0) || (int'(instr[15:8]) > VEC_ELEMS)) begin
            vl_accept = VL_W'(VEC_ELEMS);
        end
    end

    // Current beat is the last one once it covers element vl-1.
    assign beat_last = ((int'(beat_q) + 1) * LANES) >= int'(vl_q);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if ((instr[31:28] == OP_NOP) || (instr[31:28] >= OP_FIRST_ILLEGAL))
                        state_d = ST_DONE;
                    else if (instr[31:28] == OP_LOAD)
                        state_d = ST_LOAD;
                    else if (instr[31:28] == OP_STORE)
                        state_d = ST_STORE;
                    else
                        state_d = ST_EXEC;
                end
            end
            ST_EXEC:  if (beat_last) state_d = ST_DONE;
            ST_LOAD:  if (in_valid && beat_last) state_d = ST_DONE;
            ST_STORE: if (out_ready && beat_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake/status outputs and the masked STORE beat.
    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        in_ready    = (state_q == ST_LOAD);
        out_valid   = (state_q == ST_STORE);
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        err         = (state_q == ST_DONE) && (op_q >= OP_FIRST_ILLEGAL);
        out_data    = '0;
        if (state_q == ST_STORE) begin
            for (int k = 0; k < LANES; k++) begin
                if ((int'(beat_q) * LANES + k) < int'(vl_q)) begin
                    out_data[k*ELEM_W +: ELEM_W] =
                        rf_q[src1_q][EIDX_W'(int'(beat_q) * LANES + k)];
                end
            end
        end
    end

    // Datapath: instruction capture, beat counter, register file and
    // accumulator updates. Reads always come from the pre-beat (_q) copy, so
    // dest may alias either source.
    always_comb begin
        logic [EIDX_W-1:0]       e;
        logic signed [ACC_W-1:0] a_w;
        logic signed [ACC_W-1:0] b_w;
        logic signed [ACC_W-1:0] wide;
        logic signed [ACC_W-1:0] acc_new;
        int                      idx;

        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        dest_d  = dest_q;
        sat_d   = sat_q;
        clr_d   = clr_q;
        vl_d    = vl_q;
        beat_d  = beat_q;
        rf_d    = rf_q;
        acc_d   = acc_q;
        e       = '0;
        a_w     = '0;
        b_w     = '0;
        wide    = '0;
        acc_new = '0;
        idx     = 0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    op_d   = instr[31:28];
                    src1_d = instr[27:24];
                    src2_d = instr[23:20];
                    dest_d = instr[19:16];
                    vl_d   = vl_accept;
                    sat_d  = instr[0];
                    clr_d  = instr[1];
                    beat_d = '0;
                end
            end
            ST_EXEC: begin
                beat_d = beat_q + BEAT_W'(1);
                for (int k = 0; k < LANES; k++) begin
                    idx = int'(beat_q) * LANES + k;
                    if (idx < int'(vl_q)) begin
                        e   = EIDX_W'(idx);
                        a_w = sext(rf_q[src1_q][e]);
                        b_w = sext(rf_q[src2_q][e]);
                        case (op_q)
                            OP_ADD:  wide = a_w + b_w;
                            OP_SUB:  wide = a_w - b_w;
                            OP_MUL:  wide = a_w * b_w;
                            OP_MAC: begin
                                acc_new  = (clr_q ? '0 : acc_q[e]) + a_w * b_w;
                                acc_d[e] = acc_new;
                                wide     = acc_new;
                            end
                            OP_MIN:  wide = (a_w < b_w) ? a_w : b_w;
                            OP_MAX:  wide = (a_w > b_w) ? a_w : b_w;
                            OP_MOVE: wide = a_w;
                            default: wide = a_w;
                        endcase
                        rf_d[dest_q][e] = clamp(wide, sat_q);
                    end
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    beat_d = beat_q + BEAT_W'(1);
                    for (int k = 0; k < LANES; k++) begin
                        idx = int'(beat_q) * LANES + k;
                        if (idx < int'(vl_q)) begin
                            rf_d[dest_q][EIDX_W'(idx)] = in_data[k*ELEM_W +: ELEM_W];
                        end
                    end
                end
            end
            ST_STORE: begin
                if (out_ready) beat_d = beat_q + BEAT_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers; reset wipes the register file so an aborted
    // instruction leaves nothing behind.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dest_q <= '0;
            sat_q  <= 1'b0;
            clr_q  <= 1'b0;
            vl_q   <= '0;
            beat_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int i = 0; i < VEC_ELEMS; i++) begin
                    rf_q[r][i] <= '0;
                end
            end
            for (int i = 0; i < VEC_ELEMS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            op_q   <= op_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
            dest_q <= dest_d;
            sat_q  <= sat_d;
            clr_q  <= clr_d;
            vl_q   <= vl_d;
            beat_q <= beat_d;
            rf_q   <= rf_d;
            acc_q  <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_lane_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_lane_engine
// Description : Directed self-checking bench for vector_lane_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_lane_engine;

    localparam int ELEM_W    = 16;
    localparam int LANES     = 4;
    localparam int VEC_ELEMS = 16;
    localparam int NUM_REGS  = 16;
    localparam int ACC_W     = 40;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_MAC   = 4'd6;
    localparam logic [3:0] OP_MIN   = 4'd7;
    localparam logic [3:0] OP_MAX   = 4'd8;
    localparam logic [3:0] OP_MOVE  = 4'd9;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    instr_valid;
    logic                    instr_ready;
    logic [31:0]             instr;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*ELEM_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*ELEM_W-1:0] out_data;
    logic                    busy;
    logic                    done;
    logic                    err;

    int total = 0;
    int bad   = 0;

    logic [15:0] ld_vals [VEC_ELEMS];
    logic [15:0] st_vals [VEC_ELEMS];

    vector_lane_engine #(
        .ELEM_W    (ELEM_W),
        .LANES     (LANES),
        .VEC_ELEMS (VEC_ELEMS),
        .NUM_REGS  (NUM_REGS),
        .ACC_W     (ACC_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Offer one instruction and return just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d, input logic [7:0] vl, input logic [7:0] flags);
        int n;
        instr       = {op, s1, s2, d, vl, flags};
        instr_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!instr_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) check("issue_timeout", 0, 1);
        @(posedge clock); #1;
        instr_valid = 1'b0;
    endtask

    // lat counts cycles after the accept cycle before done is seen (0 = T+1).
    task automatic wait_done(output int lat, output logic e);
        lat = 0;
        @(negedge clock);
        while (!done && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        if (!done) check("done_timeout", 0, 1);
        e = err;
        @(posedge clock); #1;
    endtask

    task automatic load_reg(input logic [3:0] d, input logic gap,
                            output int accepts, output int lat);
        int   n;
        logic e;
        issue(OP_LOAD, 4'd0, 4'd0, d, 8'd0, 8'd0);
        accepts = 0;
        for (int b = 0; b < VEC_ELEMS / LANES; b++) begin
            if (gap) begin
                in_valid = 1'b0;
                @(posedge clock); #1;
            end
            in_valid = 1'b1;
            for (int k = 0; k < LANES; k++) in_data[k*ELEM_W +: ELEM_W] = ld_vals[b*LANES+k];
            n = 0;
            @(negedge clock);
            while (!in_ready && n < 20) begin
                @(negedge clock);
                n++;
            end
            if (in_ready) accepts++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        wait_done(lat, e);
    endtask

    task automatic fill_load(input logic [3:0] d, input logic [15:0] v);
        int a, l;
        for (int i = 0; i < VEC_ELEMS; i++) ld_vals[i] = v;
        load_reg(d, 1'b0, a, l);
    endtask

    task automatic store_reg(input logic [3:0] s, input logic [7:0] vl, input logic toggle);
        int   nbeats, beats, cyc, lat;
        logic prev_stall, e;
        logic [LANES*ELEM_W-1:0] prev_data;
        for (int i = 0; i < VEC_ELEMS; i++) st_vals[i] = 16'hDEAD;
        nbeats = (vl == 8'd0) ? VEC_ELEMS / LANES : (int'(vl) + LANES - 1) / LANES;
        issue(OP_STORE, s, 4'd0, 4'd0, vl, 8'd0);
        beats      = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (beats < nbeats && cyc < 200) begin
            out_ready = toggle ? cyc[0] : 1'b1;
            @(negedge clock);
            if (out_valid) begin
                if (prev_stall) check("store_stable", out_data, prev_data);
                if (out_ready) begin
                    for (int k = 0; k < LANES; k++)
                        st_vals[beats*LANES+k] = out_data[k*ELEM_W +: ELEM_W];
                    beats++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = out_data;
                end
            end
            @(posedge clock); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (beats < nbeats) check("store_timeout", beats, nbeats);
        wait_done(lat, e);
        check("store_done_lat", lat, 0);
    endtask

    task automatic exec(input logic [3:0] op, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d, input logic [7:0] vl, input logic [7:0] flags,
                        output int lat);
        logic e;
        issue(op, s1, s2, d, vl, flags);
        wait_done(lat, e);
    endtask

    task automatic expect_all(input string tag, input logic [3:0] s, input logic [15:0] v);
        store_reg(s, 8'd0, 1'b0);
        for (int i = 0; i < VEC_ELEMS; i++) check(tag, st_vals[i], v);
    endtask

    initial begin
        int   acc_n, lat, n;
        logic e;

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clock);
        check("rst_instr_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clock); #1;

        // 1. Gapped LOAD of 1..16, then STORE with a toggling out_ready.
        for (int i = 0; i < VEC_ELEMS; i++) ld_vals[i] = 16'(i + 1);
        load_reg(4'd1, 1'b1, acc_n, lat);
        check("t1_accepts", acc_n, 4);
        check("t1_done_lat", lat, 0);
        store_reg(4'd1, 8'd0, 1'b1);
        for (int i = 0; i < VEC_ELEMS; i++) check("t1_store_elem", st_vals[i], 16'(i + 1));

        // 2. ADD saturating vs wrapping.
        fill_load(4'd1, 16'h7FF0);
        fill_load(4'd2, 16'h0020);
        exec(OP_ADD, 4'd1, 4'd2, 4'd3, 8'd0, 8'd1, lat);
        check("t2_add_lat", lat, 4);
        expect_all("t2_add_sat", 4'd3, 16'h7FFF);
        exec(OP_ADD, 4'd1, 4'd2, 4'd4, 8'd0, 8'd0, lat);
        expect_all("t2_add_wrap", 4'd4, 16'h8010);

        // 3. MAC with clear then accumulate; saturating products.
        fill_load(4'd1, 16'd3);
        fill_load(4'd2, 16'd4);
        exec(OP_MAC, 4'd1, 4'd2, 4'd5, 8'd0, 8'd2, lat);
        expect_all("t3_mac_clr", 4'd5, 16'd12);
        exec(OP_MAC, 4'd1, 4'd2, 4'd5, 8'd0, 8'd0, lat);
        expect_all("t3_mac_acc", 4'd5, 16'd24);
        fill_load(4'd1, 16'hFF38);   // -200
        fill_load(4'd2, 16'h012C);   //  300
        exec(OP_MAC, 4'd1, 4'd2, 4'd5, 8'd0, 8'd3, lat);
        expect_all("t3_mac_sat", 4'd5, 16'h8000);
        exec(OP_MUL, 4'd1, 4'd2, 4'd9, 8'd0, 8'd1, lat);
        expect_all("t3_mul_sat", 4'd9, 16'h8000);
        exec(OP_MUL, 4'd1, 4'd2, 4'd9, 8'd0, 8'd0, lat);
        expect_all("t3_mul_wrap", 4'd9, 16'h15A0);   // -60000 mod 2^16
        exec(OP_SUB, 4'd1, 4'd2, 4'd10, 8'd0, 8'd0, lat);
        expect_all("t3_sub", 4'd10, 16'hFE0C);       // -500
        exec(OP_MIN, 4'd1, 4'd2, 4'd10, 8'd0, 8'd0, lat);
        expect_all("t3_min", 4'd10, 16'hFF38);
        exec(OP_MAX, 4'd1, 4'd2, 4'd10, 8'd0, 8'd0, lat);
        expect_all("t3_max", 4'd10, 16'h012C);

        // 4. Short vector: ADD vl=5 into a prefilled register.
        for (int i = 0; i < VEC_ELEMS; i++) ld_vals[i] = 16'(1000 + i);
        load_reg(4'd6, 1'b0, acc_n, lat);
        exec(OP_ADD, 4'd1, 4'd2, 4'd6, 8'd5, 8'd0, lat);
        check("t4_vl5_lat", lat, 2);
        store_reg(4'd6, 8'd0, 1'b0);
        for (int i = 0; i < VEC_ELEMS; i++)
            check("t4_vl5_elem", st_vals[i], (i < 5) ? 16'd100 : 16'(1000 + i));
        store_reg(4'd6, 8'd5, 1'b0);
        for (int i = 0; i < 8; i++)
            check("t4_masked_store", st_vals[i], (i < 5) ? 16'd100 : 16'd0);

        // 5. Illegal opcode followed by a back-to-back MOVE.
        instr       = {4'hF, 4'd1, 4'd2, 4'd3, 8'd0, 8'd0};
        instr_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!instr_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock); #1;
        instr = {OP_MOVE, 4'd1, 4'd0, 4'd7, 8'd0, 8'd0};
        @(negedge clock);
        check("t5_done", done, 1);
        check("t5_err", err, 1);
        check("t5_not_ready", instr_ready, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("t5_ready_again", instr_ready, 1);
        @(posedge clock); #1;
        instr_valid = 1'b0;
        wait_done(lat, e);
        check("t5_move_lat", lat, 4);
        check("t5_move_err", e, 0);
        expect_all("t5_move", 4'd7, 16'hFF38);
        expect_all("t5_r3_kept", 4'd3, 16'h7FFF);

        // 6. Reset in the middle of a LOAD.
        issue(OP_LOAD, 4'd0, 4'd0, 4'd8, 8'd0, 8'd0);
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            in_data  = {4{16'h5A5A}};
            @(negedge clock);
            check("t6_in_ready", in_ready, 1);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("t6_busy", busy, 0);
        check("t6_instr_ready", instr_ready, 1);
        @(posedge clock); #1;
        expect_all("t6_r1_cleared", 4'd1, 16'h0000);
        expect_all("t6_r8_cleared", 4'd8, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
